mem_port_arb: RTL and testbench

//  Shares the single core memory port between the fetch side (I) and the

---
 rtl/mem_port_arb.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Arbitrates the fetch (I) and memory-stage (D) requesters onto one memory port and routes the in-order responses back.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration on contention instead of fixed D priority.
module mem_port_arb #(
    parameter int MAX_OUTST = 2,
    parameter int N_BITS    = 32,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [N_BITS-1:0]   i_req_addr,

    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [N_BITS-1:0]   d_req_addr,
    input  logic                d_req_we,
    input  logic [N_BITS-1:0]   d_req_wdata,
    input  logic [N_BITS/8-1:0] d_req_wstrb,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [N_BITS-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [N_BITS-1:0]   mem_req_wdata,
    output logic [N_BITS/8-1:0] mem_req_wstrb,

    input  logic                mem_rsp_valid,
    input  logic [N_BITS-1:0]   mem_rsp_data,

    output logic                i_rsp_valid,
    output logic                d_rsp_valid,
    output logic [N_BITS-1:0]   rsp_data,
    output logic [CNT_W-1:0]    outst_cnt,
    output logic                err_spur_rsp,
    output logic [1:0]          dbg_lock_state
);

    // Handshake: a transfer happens on a cycle where valid && ready are both high;
    // the source holds valid and payload stable until then. Applies to i_req_*,
    // d_req_* and mem_req_* alike.

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED_I = 2'd1,
        ST_LOCKED_D = 2'd2
    } lock_state_t;

    lock_state_t            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [MAX_OUTST-1:0]   r_fifo;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic                   r_err;

    logic                   w_can_issue;
    logic                   w_grant_d;
    logic                   w_mem_hs;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_head;

`ifdef MEM_ARB_RR_EN
    logic                   r_last_grant;
    logic                   w_contend;
    assign w_contend = i_req_valid && d_req_valid;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTST - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Slot availability uses only the registered count; a response in the
    // same cycle does not free a slot for the request.
    assign w_can_issue = (r_cnt < CNT_W'(MAX_OUTST));

    always_comb begin
        w_grant_d = d_req_valid;
        case (r_state)
            ST_LOCKED_I: w_grant_d = 1'b0;
            ST_LOCKED_D: w_grant_d = 1'b1;
            default: begin
`ifdef MEM_ARB_RR_EN
                w_grant_d = w_contend ? !r_last_grant : d_req_valid;
`else
                w_grant_d = d_req_valid;
`endif
            end
        endcase
    end

    assign mem_req_valid = w_can_issue && (i_req_valid || d_req_valid);
    assign w_mem_hs      = mem_req_valid && mem_req_ready;
    assign i_req_ready   = !w_grant_d && i_req_valid && w_mem_hs;
    assign d_req_ready   =  w_grant_d && d_req_valid && w_mem_hs;

    always_comb begin
        mem_req_addr  = i_req_addr;
        mem_req_we    = 1'b0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;
        if (w_grant_d) begin
            mem_req_addr  = d_req_addr;
            mem_req_we    = d_req_we;
            mem_req_wdata = d_req_wdata;
            mem_req_wstrb = d_req_wstrb;
        end
    end

    // Responses come back in issue order, so the FIFO head names the owner.
    assign w_empty      = (r_cnt == '0);
    assign w_pop        = mem_rsp_valid && !w_empty;
    assign w_head       = r_fifo[r_rptr];
    assign i_rsp_valid  = w_pop && !w_head;
    assign d_rsp_valid  = w_pop &&  w_head;
    assign rsp_data     = mem_rsp_data;
    assign outst_cnt    = r_cnt;
    assign err_spur_rsp = r_err;
    assign dbg_lock_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_UNLOCKED;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (mem_req_valid && !mem_req_ready) begin
                        r_state <= w_grant_d ? ST_LOCKED_D : ST_LOCKED_I;
                    end
                end
                ST_LOCKED_I, ST_LOCKED_D: begin
                    if (w_mem_hs) begin
                        r_state <= ST_UNLOCKED;
                    end
                end
                default: r_state <= ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_fifo <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_mem_hs) begin
                r_fifo[r_wptr] <= w_grant_d;
                r_wptr         <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_mem_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            // Sticky until reset so a stray response is never lost to software.
            if (mem_rsp_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b0;
        end else if (w_mem_hs) begin
            r_last_grant <= w_grant_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: reset-held vector table, directed corner sequences, random traffic vs. a queue model.
module tb_mem_port_arb;

    localparam int MAX_OUTST = 2;
    localparam int N_BITS    = 32;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_req_valid = 1'b0;
    logic                i_req_ready;
    logic [N_BITS-1:0]   i_req_addr = '0;
    logic                d_req_valid = 1'b0;
    logic                d_req_ready;
    logic [N_BITS-1:0]   d_req_addr = '0;
    logic                d_req_we = 1'b0;
    logic [N_BITS-1:0]   d_req_wdata = '0;
    logic [N_BITS/8-1:0] d_req_wstrb = '0;
    logic                mem_req_valid;
    logic                mem_req_ready = 1'b0;
    logic [N_BITS-1:0]   mem_req_addr;
    logic                mem_req_we;
    logic [N_BITS-1:0]   mem_req_wdata;
    logic [N_BITS/8-1:0] mem_req_wstrb;
    logic                mem_rsp_valid = 1'b0;
    logic [N_BITS-1:0]   mem_rsp_data = '0;
    logic                i_rsp_valid;
    logic                d_rsp_valid;
    logic [N_BITS-1:0]   rsp_data;
    logic [CNT_W-1:0]    outst_cnt;
    logic                err_spur_rsp;
    logic [1:0]          dbg_lock_state;

    mem_port_arb #(.MAX_OUTST(MAX_OUTST), .N_BITS(N_BITS)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .i_rsp_valid(i_rsp_valid), .d_rsp_valid(d_rsp_valid), .rsp_data(rsp_data),
        .outst_cnt(outst_cnt), .err_spur_rsp(err_spur_rsp),
        .dbg_lock_state(dbg_lock_state)
    );

    // Clock and counters
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owners of in-flight requests (0 = I, 1 = D), in order
    logic [0:0] exp_q[$];
    logic       m_lock   = 1'b0;
    logic       m_owner  = 1'b0;
    logic       m_last   = 1'b0;
    logic       m_err    = 1'b0;

    logic e_ir, e_dr;
    logic obs_i_ready, obs_d_ready, obs_i_rsp, obs_d_rsp;
    logic [N_BITS-1:0] obs_addr, obs_rsp_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver + model step: apply inputs, compare outputs against the model, clock once.
    task automatic step(input logic iv, input logic [N_BITS-1:0] ia,
                        input logic dv, input logic [N_BITS-1:0] da, input logic dwe,
                        input logic [N_BITS-1:0] dwd, input logic [N_BITS/8-1:0] dws,
                        input logic mrdy, input logic rspv, input logic [N_BITS-1:0] rspd);
        int   sz;
        logic can, gd, mv, hs, pop_ok;
        i_req_valid = iv; i_req_addr = ia;
        d_req_valid = dv; d_req_addr = da; d_req_we = dwe; d_req_wdata = dwd; d_req_wstrb = dws;
        mem_req_ready = mrdy; mem_rsp_valid = rspv; mem_rsp_data = rspd;
        #1;
        sz  = exp_q.size();
        can = (sz < MAX_OUTST);
        if (m_lock) gd = m_owner;
`ifdef MEM_ARB_RR_EN
        else if (iv && dv) gd = !m_last;
`endif
        else gd = dv;
        mv     = can && (iv || dv);
        e_ir   = !gd && iv && can && mrdy;
        e_dr   =  gd && dv && can && mrdy;
        pop_ok = rspv && (sz > 0);

        chk("mem_req_valid", mem_req_valid, mv);
        if (mv) begin
            chk("mem_req_addr",  mem_req_addr,  gd ? da : ia);
            chk("mem_req_we",    mem_req_we,    gd ? dwe : 1'b0);
            chk("mem_req_wdata", mem_req_wdata, gd ? dwd : '0);
            chk("mem_req_wstrb", mem_req_wstrb, gd ? dws : '0);
        end
        chk("i_req_ready", i_req_ready, e_ir);
        chk("d_req_ready", d_req_ready, e_dr);
        chk("i_rsp_valid", i_rsp_valid, pop_ok && (exp_q[0] == 1'b0));
        chk("d_rsp_valid", d_rsp_valid, pop_ok && (exp_q[0] == 1'b1));
        if (pop_ok) chk("rsp_data", rsp_data, rspd);
        chk("outst_cnt", outst_cnt, sz);
        chk("err_spur_rsp", err_spur_rsp, m_err);

        obs_i_ready = i_req_ready; obs_d_ready = d_req_ready;
        obs_i_rsp = i_rsp_valid; obs_d_rsp = d_rsp_valid;
        obs_addr = mem_req_addr; obs_rsp_data = rsp_data;

        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_lock = 1'b0; m_last = 1'b0; m_err = 1'b0;
        end else begin
            hs = mv && mrdy;
            if (pop_ok) void'(exp_q.pop_front());
            if (rspv && sz == 0) m_err = 1'b1;
            if (hs) begin
                exp_q.push_back(gd);
                m_last = gd;
            end
            if (!m_lock && mv && !mrdy) begin
                m_lock = 1'b1; m_owner = gd;
            end else if (m_lock && hs) begin
                m_lock = 1'b0;
            end
        end
        #2;
    endtask

    task automatic idle(input logic rspv, input logic [N_BITS-1:0] rspd);
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b1, rspv, rspd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0, '0);
        idle(1'b0, '0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic iv, dv, dwe, mrdy, rspv;
        logic e_mv, e_ir, e_dr, e_we, e_rsp;
        logic [N_BITS-1:0] e_addr, e_wdata;
    } vec_t;

    vec_t vecs[8];

    logic i_pend, d_pend, d_we_r;
    logic [N_BITS-1:0] i_a, d_a, d_wd;
    logic [N_BITS/8-1:0] d_ws;

    initial begin
        // Arbitration table, evaluated against the reset state (rst held high)
        vecs[0] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h0};
        vecs[1] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 32'h100, 32'h0};
        vecs[2] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0, 32'h200, 32'h55};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0, 32'h200, 32'h55};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, 32'h200, 32'h55};
        vecs[5] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h0};
        vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h0};
        vecs[7] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0, 32'h100, 32'h0};

        // Initial reset, then reset-state checks
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_outst_cnt", outst_cnt, 0);
        chk("rst_err", err_spur_rsp, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_i_req_ready", i_req_ready, 0);
        chk("rst_d_req_ready", d_req_ready, 0);
        chk("rst_rsp_valid", i_rsp_valid | d_rsp_valid, 0);

        for (int k = 0; k < 8; k++) begin
            i_req_valid = vecs[k].iv; i_req_addr = 32'h100;
            d_req_valid = vecs[k].dv; d_req_addr = 32'h200; d_req_we = vecs[k].dwe;
            d_req_wdata = 32'h55; d_req_wstrb = 4'hF;
            mem_req_ready = vecs[k].mrdy; mem_rsp_valid = vecs[k].rspv; mem_rsp_data = 32'h77;
            #1;
            chk("vec_mem_req_valid", mem_req_valid, vecs[k].e_mv);
            chk("vec_i_req_ready", i_req_ready, vecs[k].e_ir);
            chk("vec_d_req_ready", d_req_ready, vecs[k].e_dr);
            chk("vec_rsp_valid", i_rsp_valid | d_rsp_valid, vecs[k].e_rsp);
            if (vecs[k].e_mv) begin
                chk("vec_mem_req_addr", mem_req_addr, vecs[k].e_addr);
                chk("vec_mem_req_we", mem_req_we, vecs[k].e_we);
                chk("vec_mem_req_wdata", mem_req_wdata, vecs[k].e_wdata);
            end
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        idle(1'b0, '0);

        // Seq 1: I load then D load, responses A then B
        do_reset();
        step(1'b1, 32'h10, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        chk("s1_cnt_a", outst_cnt, 1);
        step(1'b0, '0, 1'b1, 32'h20, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        chk("s1_cnt_b", outst_cnt, 2);
        idle(1'b0, '0);
        idle(1'b1, 32'hA);
        chk("s1_i_rsp", obs_i_rsp, 1);
        chk("s1_i_data", obs_rsp_data, 32'hA);
        chk("s1_cnt_c", outst_cnt, 1);
        idle(1'b0, '0);
        idle(1'b1, 32'hB);
        chk("s1_d_rsp", obs_d_rsp, 1);
        chk("s1_d_data", obs_rsp_data, 32'hB);
        chk("s1_cnt_d", outst_cnt, 0);

        // Seq 2: both valid every cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
`ifdef MEM_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            step(1'b1, 32'h30, 1'b1, 32'h40, 1'b0, '0, '0, 1'b1, (k > 0), 32'h1);
            chk("s2_d_grant", obs_d_ready, exp_d);
            chk("s2_i_grant", obs_i_ready, !exp_d);
        end
        idle(1'b1, 32'h1);
        chk("s2_cnt_drained", outst_cnt, 0);

        // Seq 3: I stalled by memory, D raised mid-stall; grant must hold on I
        do_reset();
        step(1'b1, 32'h30, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        chk("s3_addr0", obs_addr, 32'h30);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 32'h30, 1'b1, 32'h40, 1'b1, 32'h99, 4'h3, 1'b0, 1'b0, '0);
            chk("s3_addr_hold", obs_addr, 32'h30);
        end
        step(1'b1, 32'h30, 1'b1, 32'h40, 1'b1, 32'h99, 4'h3, 1'b1, 1'b0, '0);
        chk("s3_i_accept", obs_i_ready, 1);
        chk("s3_addr_i", obs_addr, 32'h30);
        step(1'b0, '0, 1'b1, 32'h40, 1'b1, 32'h99, 4'h3, 1'b1, 1'b0, '0);
        chk("s3_d_accept", obs_d_ready, 1);
        chk("s3_addr_d", obs_addr, 32'h40);
        idle(1'b1, 32'h5);
        idle(1'b1, 32'h6);

        // Seq 4: full FIFO, third request with simultaneous response
        do_reset();
        step(1'b1, 32'h50, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        step(1'b1, 32'h54, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        chk("s4_cnt_full", outst_cnt, 2);
        step(1'b1, 32'h58, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h7);
        chk("s4_held_off", obs_i_ready, 0);
        chk("s4_cnt_1", outst_cnt, 1);
        step(1'b1, 32'h58, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        chk("s4_accepted", obs_i_ready, 1);
        chk("s4_cnt_2", outst_cnt, 2);
        idle(1'b1, 32'h8);
        idle(1'b1, 32'h9);

        // Seq 5: spurious response is dropped and sticky
        do_reset();
        idle(1'b1, 32'hDEAD);
        chk("s5_no_rsp", obs_i_rsp | obs_d_rsp, 0);
        chk("s5_err_set", err_spur_rsp, 1);
        step(1'b1, 32'h60, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        idle(1'b1, 32'h61);
        idle(1'b0, '0);
        chk("s5_err_sticky", err_spur_rsp, 1);
        do_reset();
        chk("s5_err_cleared", err_spur_rsp, 0);

        // Seq 6: reset with two requests in flight
        step(1'b1, 32'h70, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 32'h74, 1'b1, 32'h1, 4'h1, 1'b1, 1'b0, '0);
        chk("s6_cnt_2", outst_cnt, 2);
        rst = 1'b1;
        idle(1'b0, '0);
        rst = 1'b0;
        chk("s6_cnt_0", outst_cnt, 0);
        idle(1'b1, 32'h3);
        chk("s6_late_no_rsp", obs_i_rsp | obs_d_rsp, 0);
        chk("s6_late_err", err_spur_rsp, 1);

        // Random traffic against the model
        do_reset();
        i_pend = 1'b0; d_pend = 1'b0;
        i_a = '0; d_a = '0; d_we_r = 1'b0; d_wd = '0; d_ws = '0;
        for (int c = 0; c < 1500; c++) begin
            logic rv;
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1'b1; i_a = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; d_a = $urandom; d_we_r = 1'($urandom_range(0, 1));
                d_wd = $urandom; d_ws = 4'($urandom_range(0, 15));
            end
            rv = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            step(i_pend, i_a, d_pend, d_a, d_we_r, d_wd, d_ws,
                 ($urandom_range(0, 3) != 0), rv, $urandom);
            if (e_ir) i_pend = 1'b0;
            if (e_dr) d_pend = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
